// File: rtl/data_checker.sv
// Receive-side checker that locks onto an incrementing (+1) test-data stream and counts errors.
// Optional first-error capture ports are enabled by defining DATA_CHECKER_FIRST_ERR_EN.
module data_checker #(
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              err_pulse,
`ifdef DATA_CHECKER_FIRST_ERR_EN
    output logic [DATA_W-1:0] first_err_data,
    output logic [DATA_W-1:0] first_err_exp,
    output logic              first_err_vld,
`endif
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  word_cnt
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_TGT = 8'(LOSS_CNT);

    state_e            state_q;
    logic              seeded_q;
    logic [DATA_W-1:0] expected_q;
    logic [7:0]        match_run_q;
    logic [7:0]        miss_run_q;
    logic              err_pulse_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [CNT_W-1:0]  word_cnt_q;

    logic              match_d;
    logic [DATA_W-1:0] reseed_d;
    logic [DATA_W-1:0] expected_inc_d;
    logic [CNT_W-1:0]  err_cnt_d;
    logic [CNT_W-1:0]  word_cnt_d;

    assign match_d        = (data_in == expected_q);
    assign reseed_d       = data_in + DATA_W'(1);
    assign expected_inc_d = expected_q + DATA_W'(1);

    // Saturating increments: counters stick at all-ones instead of wrapping.
    assign err_cnt_d  = (err_cnt_q  == '1) ? err_cnt_q  : err_cnt_q  + CNT_W'(1);
    assign word_cnt_d = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            seeded_q    <= 1'b0;
            expected_q  <= '0;
            match_run_q <= '0;
            miss_run_q  <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (data_valid) begin
                case (state_q)
                    HUNT: begin
                        if (!seeded_q || !match_d) begin
                            seeded_q    <= 1'b1;
                            expected_q  <= reseed_d;
                            match_run_q <= '0;
                        end else begin
                            expected_q  <= expected_inc_d;
                            match_run_q <= match_run_q + 8'd1;
                            if (match_run_q + 8'd1 == LOCK_TGT) begin
                                state_q    <= LOCKED;
                                miss_run_q <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        word_cnt_q <= word_cnt_d;
                        if (match_d) begin
                            expected_q <= expected_inc_d;
                            miss_run_q <= '0;
                        end else begin
                            err_pulse_q <= 1'b1;
                            err_cnt_q   <= err_cnt_d;
                            miss_run_q  <= miss_run_q + 8'd1;
                            expected_q  <= reseed_d;
                            if (miss_run_q + 8'd1 == LOSS_TGT) begin
                                state_q  <= HUNT;
                                seeded_q <= 1'b0;
                            end
                        end
                    end
                endcase
            end
            // NOTE: the later non-blocking assignment wins, giving clr_cnt priority over a coincident count.
            if (clr_cnt) begin
                err_cnt_q  <= '0;
                word_cnt_q <= '0;
            end
        end
    end

`ifdef DATA_CHECKER_FIRST_ERR_EN
    logic [DATA_W-1:0] first_err_data_q;
    logic [DATA_W-1:0] first_err_exp_q;
    logic              first_err_vld_q;
    logic              capture_d;

    assign capture_d = data_valid && (state_q == LOCKED) && !match_d && !first_err_vld_q;

    // Value registers only load on capture; clr_cnt just drops the valid flag to re-arm.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_err_data_q <= '0;
            first_err_exp_q  <= '0;
            first_err_vld_q  <= 1'b0;
        end else begin
            if (capture_d) begin
                first_err_data_q <= data_in;
                first_err_exp_q  <= expected_q;
                first_err_vld_q  <= 1'b1;
            end
            if (clr_cnt) begin
                first_err_vld_q <= 1'b0;
            end
        end
    end

    assign first_err_data = first_err_data_q;
    assign first_err_exp  = first_err_exp_q;
    assign first_err_vld  = first_err_vld_q;
`endif

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_data_checker.sv
// Self-checking bench for data_checker: directed scenarios plus randomized traffic
// compared against a behavioural model of the lock/count rules.
module tb_data_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int CNT_MAX  = 65535;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic [15:0] word_cnt;
`ifdef DATA_CHECKER_FIRST_ERR_EN
    logic [7:0]  first_err_data;
    logic [7:0]  first_err_exp;
    logic        first_err_vld;
`endif

    int checks = 0;
    int errors = 0;

    data_checker #(
        .DATA_W  (8),
        .CNT_W   (16),
        .LOCK_CNT(LOCK_CNT),
        .LOSS_CNT(LOSS_CNT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .clr_cnt       (clr_cnt),
        .locked        (locked),
        .err_pulse     (err_pulse),
`ifdef DATA_CHECKER_FIRST_ERR_EN
        .first_err_data(first_err_data),
        .first_err_exp (first_err_exp),
        .first_err_vld (first_err_vld),
`endif
        .err_cnt       (err_cnt),
        .word_cnt      (word_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural reference model, plain integers
    bit m_locked, m_seeded, m_pulse;
    int m_exp, m_run, m_miss, m_err, m_words;
    bit m_fe_vld;
    int m_fe_data, m_fe_exp;

    function automatic int sat(input int x);
        return (x > CNT_MAX) ? CNT_MAX : x;
    endfunction

    function automatic void model_reset();
        m_locked = 0; m_seeded = 0; m_pulse = 0;
        m_exp = 0; m_run = 0; m_miss = 0; m_err = 0; m_words = 0;
        m_fe_vld = 0; m_fe_data = 0; m_fe_exp = 0;
    endfunction

    function automatic void model_step(input bit v, input int d, input bit c);
        m_pulse = 0;
        if (v) begin
            if (!m_locked) begin
                if (!m_seeded || d != m_exp) begin
                    m_seeded = 1;
                    m_exp = (d + 1) % 256;
                    m_run = 0;
                end else begin
                    m_run = m_run + 1;
                    m_exp = (m_exp + 1) % 256;
                    if (m_run >= LOCK_CNT) begin
                        m_locked = 1;
                        m_miss = 0;
                    end
                end
            end else begin
                m_words = sat(m_words + 1);
                if (d == m_exp) begin
                    m_exp = (m_exp + 1) % 256;
                    m_miss = 0;
                end else begin
                    m_pulse = 1;
                    m_err = sat(m_err + 1);
                    if (!m_fe_vld) begin
                        m_fe_vld = 1;
                        m_fe_data = d;
                        m_fe_exp = m_exp;
                    end
                    m_miss = m_miss + 1;
                    m_exp = (d + 1) % 256;
                    if (m_miss >= LOSS_CNT) begin
                        m_locked = 0;
                        m_seeded = 0;
                    end
                end
            end
        end
        if (c) begin
            m_err = 0;
            m_words = 0;
            m_fe_vld = 0;
        end
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, settle #1 past the edge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit c);
        data_valid = v;
        data_in    = d;
        clr_cnt    = c;
        @(posedge clk);
        model_step(v, int'(d), c);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 8'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        data_valid = 1'b0;
        data_in = 8'h00;
        clr_cnt = 1'b0;
        model_reset();
        #25;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0h expected 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse: got %0h expected 0", err_pulse); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt: got %0h expected 0", err_cnt); end
        checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL reset_word_cnt: got %0h expected 0", word_cnt); end
`ifdef DATA_CHECKER_FIRST_ERR_EN
        checks++; if (first_err_vld !== 1'b0) begin errors++; $display("FAIL reset_fe_vld: got %0h expected 0", first_err_vld); end
        checks++; if (first_err_data !== 8'h00 || first_err_exp !== 8'h00) begin
            errors++; $display("FAIL reset_fe_vals: got %0h/%0h expected 0/0", first_err_data, first_err_exp);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_lock();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            if (i == 3) begin
                checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %0h expected 0", locked); end
            end
            if (i == 4) begin
                checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise: got %0h expected 1", locked); end
            end
        end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL lock_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if (word_cnt !== 16'd5) begin errors++; $display("FAIL lock_word_cnt: got %0d expected 5", word_cnt); end
    endtask

    task automatic test_single_error();
        for (int d = 8'h0A; d <= 8'h14; d++) cycle(1'b1, 8'(d), 1'b0);
        cycle(1'b1, 8'h20, 1'b0);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse: got %0h expected 1", err_pulse); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL single_err_cnt: got %0d expected 1", err_cnt); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked: got %0h expected 1", locked); end
`ifdef DATA_CHECKER_FIRST_ERR_EN
        checks++; if (first_err_data !== 8'h20 || first_err_exp !== 8'h15 || first_err_vld !== 1'b1) begin
            errors++; $display("FAIL fe_capture: got %0h/%0h/%0h expected 20/15/1", first_err_data, first_err_exp, first_err_vld);
        end
`endif
        cycle(1'b1, 8'h21, 1'b0);
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL resync_pulse: got %0h expected 0", err_pulse); end
        checks++; if (err_cnt !== 16'd1 || locked !== 1'b1) begin
            errors++; $display("FAIL resync_state: got cnt %0d lock %0h expected 1/1", err_cnt, locked);
        end
        cycle(1'b1, 8'h40, 1'b0);
        checks++; if (err_pulse !== 1'b1 || err_cnt !== 16'd2) begin
            errors++; $display("FAIL second_err: got pulse %0h cnt %0d expected 1/2", err_pulse, err_cnt);
        end
        cycle(1'b1, 8'h41, 1'b0);
`ifdef DATA_CHECKER_FIRST_ERR_EN
        checks++; if (first_err_data !== 8'h20 || first_err_exp !== 8'h15 || first_err_vld !== 1'b1) begin
            errors++; $display("FAIL fe_hold: got %0h/%0h/%0h expected 20/15/1", first_err_data, first_err_exp, first_err_vld);
        end
`endif
        checks++; if (word_cnt !== 16'(m_words)) begin errors++; $display("FAIL single_word_cnt: got %0d expected %0d", word_cnt, m_words); end
    endtask

    task automatic test_wrap();
        int base;
        logic [7:0] w;
        for (int d = 8'h42; d <= 8'hFC; d++) cycle(1'b1, 8'(d), 1'b0);
        base = m_words;
        w = 8'hFD;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, w, 1'b0);
            checks++; if (err_pulse !== 1'b0 || locked !== 1'b1) begin
                errors++; $display("FAIL wrap_word%0d: got pulse %0h lock %0h expected 0/1", k, err_pulse, locked);
            end
            idle();
            idle();
            w = w + 8'd1;
        end
        checks++; if (word_cnt !== 16'(base + 5)) begin errors++; $display("FAIL wrap_word_cnt: got %0d expected %0d", word_cnt, base + 5); end
    endtask

    task automatic test_loss();
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (err_cnt !== 16'd0 || word_cnt !== 16'd0) begin
            errors++; $display("FAIL clr_idle: got %0d/%0d expected 0/0", err_cnt, word_cnt);
        end
        cycle(1'b1, 8'h50, 1'b0);
        checks++; if (err_pulse !== 1'b1 || locked !== 1'b1) begin
            errors++; $display("FAIL loss_first: got pulse %0h lock %0h expected 1/1", err_pulse, locked);
        end
        cycle(1'b1, 8'h10, 1'b0);
        checks++; if (err_pulse !== 1'b1 || locked !== 1'b1) begin
            errors++; $display("FAIL loss_second: got pulse %0h lock %0h expected 1/1", err_pulse, locked);
        end
        cycle(1'b1, 8'h70, 1'b0);
        checks++; if (err_pulse !== 1'b1 || locked !== 1'b0 || err_cnt !== 16'd3) begin
            errors++; $display("FAIL loss_third: got pulse %0h lock %0h cnt %0d expected 1/0/3", err_pulse, locked, err_cnt);
        end
`ifdef DATA_CHECKER_FIRST_ERR_EN
        checks++; if (first_err_data !== 8'h50 || first_err_exp !== 8'h02 || first_err_vld !== 1'b1) begin
            errors++; $display("FAIL fe_rearm: got %0h/%0h/%0h expected 50/02/1", first_err_data, first_err_exp, first_err_vld);
        end
`endif
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'(8'h30 + i), 1'b0);
            checks++; if (err_pulse !== 1'b0 || locked !== (i == 4)) begin
                errors++; $display("FAIL relock_%0d: got pulse %0h lock %0h expected 0/%0d", i, err_pulse, locked, i == 4);
            end
        end
        checks++; if (err_cnt !== 16'd3 || word_cnt !== 16'd3) begin
            errors++; $display("FAIL relock_cnts: got %0d/%0d expected 3/3", err_cnt, word_cnt);
        end
    endtask

    task automatic test_clr_and_async_reset();
        cycle(1'b1, 8'h99, 1'b1);
        checks++; if (err_pulse !== 1'b1 || err_cnt !== 16'd0 || word_cnt !== 16'd0 || locked !== 1'b1) begin
            errors++; $display("FAIL clr_coincident: got pulse %0h cnt %0d/%0d lock %0h expected 1 0/0 1", err_pulse, err_cnt, word_cnt, locked);
        end
        for (int d = 8'h9A; d <= 8'h9E; d++) cycle(1'b1, 8'(d), 1'b0);
        checks++; if (word_cnt !== 16'd5 || err_cnt !== 16'd0) begin
            errors++; $display("FAIL post_clr_count: got %0d/%0d expected 5/0", word_cnt, err_cnt);
        end
        rst = 1'b0;
        #2;
        model_reset();
        checks++; if (locked !== 1'b0 || word_cnt !== 16'd0 || err_cnt !== 16'd0 || err_pulse !== 1'b0) begin
            errors++; $display("FAIL async_reset: got lock %0h cnt %0d/%0d pulse %0h expected 0 0/0 0", locked, err_cnt, word_cnt, err_pulse);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'(8'hC0 + i), 1'b0);
            checks++; if (locked !== (i == 4)) begin
                errors++; $display("FAIL rehunt_%0d: got %0h expected %0d", i, locked, i == 4);
            end
        end
    endtask

    task automatic test_random();
        bit v, c;
        logic [7:0] d;
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 99) < 75);
            c = ($urandom_range(0, 99) < 3);
            d = ($urandom_range(0, 99) < 85) ? 8'(m_exp) : 8'($urandom_range(0, 255));
            cycle(v, d, c);
            checks++; if (locked !== m_locked) begin errors++; $display("FAIL rand_locked@%0d: got %0h expected %0h", n, locked, m_locked); end
            checks++; if (err_pulse !== m_pulse) begin errors++; $display("FAIL rand_pulse@%0d: got %0h expected %0h", n, err_pulse, m_pulse); end
            checks++; if (err_cnt !== 16'(m_err)) begin errors++; $display("FAIL rand_err_cnt@%0d: got %0d expected %0d", n, err_cnt, m_err); end
            checks++; if (word_cnt !== 16'(m_words)) begin errors++; $display("FAIL rand_word_cnt@%0d: got %0d expected %0d", n, word_cnt, m_words); end
`ifdef DATA_CHECKER_FIRST_ERR_EN
            checks++; if (first_err_vld !== m_fe_vld || (m_fe_vld && (first_err_data !== 8'(m_fe_data) || first_err_exp !== 8'(m_fe_exp)))) begin
                errors++; $display("FAIL rand_fe@%0d: got %0h/%0h/%0h expected %0h/%0h/%0h", n, first_err_data, first_err_exp, first_err_vld, m_fe_data, m_fe_exp, m_fe_vld);
            end
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_wrap();
        test_loss();
        test_clr_and_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
